// File: rtl/round_constant_seq_if.sv
// Handshake bundle between the SHA-2 round-constant sequencer and the compression datapath.
// The sequencer drives the constant stream; the consumer drives start/abort/i_ready.
interface round_constant_seq_if #(
    parameter int WRD_SIZE = 32,
    parameter int ADDR_WTH = 7
);
    logic                start;
    logic                abort;
    logic                i_ready;
    logic                o_valid;
    logic [WRD_SIZE-1:0] o_round_constant;
    logic [ADDR_WTH-1:0] o_round_idx;
    logic                o_last;
    logic                o_done;
    logic                o_busy;

    modport master (
        input  start,
        input  abort,
        input  i_ready,
        output o_valid,
        output o_round_constant,
        output o_round_idx,
        output o_last,
        output o_done,
        output o_busy
    );

    modport slave (
        output start,
        output abort,
        output i_ready,
        input  o_valid,
        input  o_round_constant,
        input  o_round_idx,
        input  o_last,
        input  o_done,
        input  o_busy
    );
endinterface

// File: rtl/round_constant_seq.sv
// Self-sequencing SHA-2 round-constant source: walks K[0..ROUNDS-1] under valid/ready.
// WRD_SIZE=64 gives SHA-512 K (80 rounds); WRD_SIZE=32 gives the upper halves (SHA-256, 64 rounds).
module round_constant_seq #(
    parameter int WRD_SIZE = 32,
    parameter int ADDR_WTH = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    round_constant_seq_if.master bus
);
    localparam int                ROUNDS   = (WRD_SIZE == 64) ? 80 : 64;
    localparam logic [ADDR_WTH-1:0] LAST_IDX = ADDR_WTH'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_WTH-1:0] idx_p1, idx_nxt;
    logic [WRD_SIZE-1:0] const_p1, const_nxt;
    logic                vld_p1, vld_nxt;
    logic                done_p1, done_nxt;

    // SHA-256 constants are exactly the upper 32 bits of the SHA-512 set.
    function automatic logic [63:0] k512(input logic [6:0] i);
        case (i)
            7'd0:  k512 = 64'h428a2f98d728ae22;
            7'd1:  k512 = 64'h7137449123ef65cd;
            7'd2:  k512 = 64'hb5c0fbcfec4d3b2f;
            7'd3:  k512 = 64'he9b5dba58189dbbc;
            7'd4:  k512 = 64'h3956c25bf348b538;
            7'd5:  k512 = 64'h59f111f1b605d019;
            7'd6:  k512 = 64'h923f82a4af194f9b;
            7'd7:  k512 = 64'hab1c5ed5da6d8118;
            7'd8:  k512 = 64'hd807aa98a3030242;
            7'd9:  k512 = 64'h12835b0145706fbe;
            7'd10: k512 = 64'h243185be4ee4b28c;
            7'd11: k512 = 64'h550c7dc3d5ffb4e2;
            7'd12: k512 = 64'h72be5d74f27b896f;
            7'd13: k512 = 64'h80deb1fe3b1696b1;
            7'd14: k512 = 64'h9bdc06a725c71235;
            7'd15: k512 = 64'hc19bf174cf692694;
            7'd16: k512 = 64'he49b69c19ef14ad2;
            7'd17: k512 = 64'hefbe4786384f25e3;
            7'd18: k512 = 64'h0fc19dc68b8cd5b5;
            7'd19: k512 = 64'h240ca1cc77ac9c65;
            7'd20: k512 = 64'h2de92c6f592b0275;
            7'd21: k512 = 64'h4a7484aa6ea6e483;
            7'd22: k512 = 64'h5cb0a9dcbd41fbd4;
            7'd23: k512 = 64'h76f988da831153b5;
            7'd24: k512 = 64'h983e5152ee66dfab;
            7'd25: k512 = 64'ha831c66d2db43210;
            7'd26: k512 = 64'hb00327c898fb213f;
            7'd27: k512 = 64'hbf597fc7beef0ee4;
            7'd28: k512 = 64'hc6e00bf33da88fc2;
            7'd29: k512 = 64'hd5a79147930aa725;
            7'd30: k512 = 64'h06ca6351e003826f;
            7'd31: k512 = 64'h142929670a0e6e70;
            7'd32: k512 = 64'h27b70a8546d22ffc;
            7'd33: k512 = 64'h2e1b21385c26c926;
            7'd34: k512 = 64'h4d2c6dfc5ac42aed;
            7'd35: k512 = 64'h53380d139d95b3df;
            7'd36: k512 = 64'h650a73548baf63de;
            7'd37: k512 = 64'h766a0abb3c77b2a8;
            7'd38: k512 = 64'h81c2c92e47edaee6;
            7'd39: k512 = 64'h92722c851482353b;
            7'd40: k512 = 64'ha2bfe8a14cf10364;
            7'd41: k512 = 64'ha81a664bbc423001;
            7'd42: k512 = 64'hc24b8b70d0f89791;
            7'd43: k512 = 64'hc76c51a30654be30;
            7'd44: k512 = 64'hd192e819d6ef5218;
            7'd45: k512 = 64'hd69906245565a910;
            7'd46: k512 = 64'hf40e35855771202a;
            7'd47: k512 = 64'h106aa07032bbd1b8;
            7'd48: k512 = 64'h19a4c116b8d2d0c8;
            7'd49: k512 = 64'h1e376c085141ab53;
            7'd50: k512 = 64'h2748774cdf8eeb99;
            7'd51: k512 = 64'h34b0bcb5e19b48a8;
            7'd52: k512 = 64'h391c0cb3c5c95a63;
            7'd53: k512 = 64'h4ed8aa4ae3418acb;
            7'd54: k512 = 64'h5b9cca4f7763e373;
            7'd55: k512 = 64'h682e6ff3d6b2b8a3;
            7'd56: k512 = 64'h748f82ee5defb2fc;
            7'd57: k512 = 64'h78a5636f43172f60;
            7'd58: k512 = 64'h84c87814a1f0ab72;
            7'd59: k512 = 64'h8cc702081a6439ec;
            7'd60: k512 = 64'h90befffa23631e28;
            7'd61: k512 = 64'ha4506cebde82bde9;
            7'd62: k512 = 64'hbef9a3f7b2c67915;
            7'd63: k512 = 64'hc67178f2e372532b;
            7'd64: k512 = 64'hca273eceea26619c;
            7'd65: k512 = 64'hd186b8c721c0c207;
            7'd66: k512 = 64'heada7dd6cde0eb1e;
            7'd67: k512 = 64'hf57d4f7fee6ed178;
            7'd68: k512 = 64'h06f067aa72176fba;
            7'd69: k512 = 64'h0a637dc5a2c898a6;
            7'd70: k512 = 64'h113f9804bef90dae;
            7'd71: k512 = 64'h1b710b35131c471b;
            7'd72: k512 = 64'h28db77f523047d84;
            7'd73: k512 = 64'h32caab7b40c72493;
            7'd74: k512 = 64'h3c9ebe0a15c9bebc;
            7'd75: k512 = 64'h431d67c49c100d4c;
            7'd76: k512 = 64'h4cc5d4becb3e42b6;
            7'd77: k512 = 64'h597f299cfc657e2a;
            7'd78: k512 = 64'h5fcb6fab3ad6faec;
            7'd79: k512 = 64'h6c44198c4a475817;
            default: k512 = 64'h0;
        endcase
    endfunction

    function automatic logic [WRD_SIZE-1:0] k_sel(input logic [ADDR_WTH-1:0] i);
        logic [63:0] full;
        full = k512(i[6:0]);
        return full[63 -: WRD_SIZE];
    endfunction

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_p1;
        const_nxt = const_p1;
        vld_nxt   = vld_p1;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    idx_nxt   = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    vld_nxt   = 1'b0;
                    const_nxt = '0;
                end else begin
                    const_nxt = k_sel(idx_p1);
                    vld_nxt   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    vld_nxt   = 1'b0;
                    const_nxt = '0;
                end else if (vld_p1 && bus.i_ready) begin
                    if (idx_p1 == LAST_IDX) begin
                        vld_nxt   = 1'b0;
                        const_nxt = '0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        // Next constant is registered on the accepting edge, so no bubble.
                        idx_nxt   = idx_p1 + ADDR_WTH'(1);
                        const_nxt = k_sel(idx_p1 + ADDR_WTH'(1));
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                vld_nxt   = 1'b0;
                const_nxt = '0;
            end
        endcase
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx_p1   <= '0;
            const_p1 <= '0;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx_p1   <= idx_nxt;
            const_p1 <= const_nxt;
            vld_p1   <= vld_nxt;
            done_p1  <= done_nxt;
        end
    end

    assign bus.o_valid          = vld_p1;
    assign bus.o_round_constant = const_p1;
    assign bus.o_round_idx      = idx_p1;
    assign bus.o_last           = vld_p1 && (idx_p1 == LAST_IDX);
    assign bus.o_done           = done_p1;
    assign bus.o_busy           = (state != IDLE);
endmodule
